// File: rtl/dbi_slave_regfile.sv
// DBI slave register file: standard bank, CS2 shadow bank, write-protect register, programmable ack latency.
// Optional feature macro: DBI_ERR_RESP_EN (error data word and dbi_err pulses on bad accesses).
module dbi_slave_regfile #(
   parameter int unsigned IDX_W        = 6,
   parameter int unsigned RO_WORDS     = 16,
   parameter int unsigned ACK_LAT      = 2,
   parameter logic [31:0] ADDR_WR_PROT = 32'h0000_08BC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        drp_dbi_cs,
   input  logic        drp_dbi_cs2_exp,
   input  logic [31:0] drp_dbi_addr,
   input  logic [31:0] drp_dbi_din,
   input  logic [3:0]  drp_dbi_wr,
   input  logic        drp_app_dbi_ro_wr_disable,
   output logic [31:0] drp_lbc_dbi_dout,
   output logic        drp_lbc_dbi_ack,
   output logic        dbi_err
);

   localparam int unsigned NWORDS = 2**IDX_W;
   localparam int unsigned CNT_W  = 4;

`ifdef DBI_ERR_RESP_EN
   localparam logic [31:0] OOR_DATA = 32'hBADA_DD0E;
   localparam logic        ERR_EN   = 1'b1;
`else
   localparam logic [31:0] OOR_DATA = 32'h0000_0000;
   localparam logic        ERR_EN   = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_addr;
   logic [31:0]        r_din;
   logic [3:0]         r_wr;
   logic               r_cs2;
   logic               r_prot;
   logic [31:0]        r_std [NWORDS];
   logic [31:0]        r_shd [NWORDS];

   logic [IDX_W-1:0]   w_idx;
   logic               w_is_prot;
   logic               w_in_rng;
   logic               w_is_rd;
   logic               w_ro_blk;
   logic               w_err;
   logic [31:0]        w_rd_data;

   function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
      logic [31:0] res;
      res = old_w;
      for (int n = 0; n < 4; n++) begin
         if (be[n]) res[8*n +: 8] = new_w[8*n +: 8];
      end
      return res;
   endfunction

   // Decode of the latched request
   always_comb begin
      w_idx     = r_addr[IDX_W+1:2];
      w_is_prot = (r_addr == ADDR_WR_PROT) && !r_cs2;
      w_in_rng  = (r_addr[31:IDX_W+2] == '0) && !w_is_prot;
      w_is_rd   = (r_wr == 4'h0);
      w_ro_blk  = !w_is_rd && !r_cs2 && w_in_rng &&
                  ({1'b0, w_idx} < (IDX_W+1)'(RO_WORDS)) &&
                  (!r_prot || drp_app_dbi_ro_wr_disable);
      w_err     = ERR_EN & ((!w_is_prot && !w_in_rng) | w_ro_blk);
      w_rd_data = OOR_DATA;
      if (w_is_prot)     w_rd_data = {31'b0, r_prot};
      else if (w_in_rng) w_rd_data = r_cs2 ? r_shd[w_idx] : r_std[w_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_addr           <= '0;
         r_din            <= '0;
         r_wr             <= '0;
         r_cs2            <= 1'b0;
         r_prot           <= 1'b0;
         drp_lbc_dbi_dout <= '0;
         drp_lbc_dbi_ack  <= 1'b0;
         dbi_err          <= 1'b0;
         for (int i = 0; i < NWORDS; i++) begin
            r_std[i] <= '0;
            r_shd[i] <= '0;
         end
      end else begin
         drp_lbc_dbi_ack <= 1'b0;
         dbi_err         <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (drp_dbi_cs) begin
                  r_addr  <= drp_dbi_addr;
                  r_din   <= drp_dbi_din;
                  r_wr    <= drp_dbi_wr;
                  r_cs2   <= drp_dbi_cs2_exp;
                  r_cnt   <= CNT_W'(ACK_LAT - 1);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!drp_dbi_cs) begin
                  r_state <= S_IDLE;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  // Edge into the ack cycle: response registered and write committed together
                  r_state         <= S_ACK;
                  drp_lbc_dbi_ack <= 1'b1;
                  dbi_err         <= w_err;
                  if (w_is_rd) begin
                     drp_lbc_dbi_dout <= w_rd_data;
                  end else if (w_is_prot) begin
                     if (r_wr[0]) r_prot <= r_din[0];
                  end else if (w_in_rng) begin
                     if (r_cs2)          r_shd[w_idx] <= f_merge(r_shd[w_idx], r_din, r_wr);
                     else if (!w_ro_blk) r_std[w_idx] <= f_merge(r_std[w_idx], r_din, r_wr);
                  end
               end
            end
            S_ACK: begin
               r_state <= S_RELEASE;
            end
            S_RELEASE: begin
               if (!drp_dbi_cs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbi_slave_regfile.sv
// Scoreboard bench for dbi_slave_regfile: directed scenarios plus randomized accesses vs. a behavioural model.
module tb_dbi_slave_regfile;

   localparam int unsigned IDX_W    = 6;
   localparam int unsigned RO_WORDS = 16;
   localparam int unsigned ACK_LAT  = 2;
   localparam logic [31:0] PROT_A   = 32'h0000_08BC;
   localparam int unsigned NW       = 2**IDX_W;

`ifdef DBI_ERR_RESP_EN
   localparam bit          ERR_EN = 1'b1;
   localparam logic [31:0] OOR_D  = 32'hBADA_DD0E;
`else
   localparam bit          ERR_EN = 1'b0;
   localparam logic [31:0] OOR_D  = 32'h0000_0000;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        drp_dbi_cs;
   logic        drp_dbi_cs2_exp;
   logic [31:0] drp_dbi_addr;
   logic [31:0] drp_dbi_din;
   logic [3:0]  drp_dbi_wr;
   logic        drp_app_dbi_ro_wr_disable;
   logic [31:0] drp_lbc_dbi_dout;
   logic        drp_lbc_dbi_ack;
   logic        dbi_err;

   dbi_slave_regfile #(.IDX_W(IDX_W), .RO_WORDS(RO_WORDS), .ACK_LAT(ACK_LAT), .ADDR_WR_PROT(PROT_A)) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .drp_dbi_cs                (drp_dbi_cs),
      .drp_dbi_cs2_exp           (drp_dbi_cs2_exp),
      .drp_dbi_addr              (drp_dbi_addr),
      .drp_dbi_din               (drp_dbi_din),
      .drp_dbi_wr                (drp_dbi_wr),
      .drp_app_dbi_ro_wr_disable (drp_app_dbi_ro_wr_disable),
      .drp_lbc_dbi_dout          (drp_lbc_dbi_dout),
      .drp_lbc_dbi_ack           (drp_lbc_dbi_ack),
      .dbi_err                   (dbi_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Reference model state
   logic [31:0] m_std [NW];
   logic [31:0] m_shd [NW];
   logic        m_prot;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp_v, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NW; i++) begin
         m_std[i] = '0;
         m_shd[i] = '0;
      end
      m_prot = 1'b0;
   endtask

   // Expected outcome of one completed access, applied to the model
   task automatic model_access(input logic cs2, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic rowd);
      exp_t e;
      int   idx;
      logic [31:0] w;
      e.rd = (be == 4'h0);
      e.data = '0;
      e.err = 1'b0;
      idx = int'(a[IDX_W+1:2]);
      if (!cs2 && a == PROT_A) begin
         if (e.rd) e.data = {31'b0, m_prot};
         else if (be[0]) m_prot = d[0];
      end else if ((a >> (IDX_W + 2)) != 0) begin
         e.data = OOR_D;
         e.err  = ERR_EN;
      end else if (e.rd) begin
         e.data = cs2 ? m_shd[idx] : m_std[idx];
      end else begin
         w = cs2 ? m_shd[idx] : m_std[idx];
         for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = d[8*n +: 8];
         if (cs2) m_shd[idx] = w;
         else if (idx < RO_WORDS && (!m_prot || rowd)) e.err = ERR_EN;
         else m_std[idx] = w;
      end
      sb_q.push_back(e);
   endtask

   task automatic drive_idle();
      drp_dbi_cs = 1'b0;
      drp_dbi_cs2_exp = 1'b0;
      drp_dbi_addr = '0;
      drp_dbi_din = '0;
      drp_dbi_wr = '0;
   endtask

   // Full master cycle: issue, hold cs until ack, check latency, release
   task automatic acc(input logic cs2, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic rowd);
      int n;
      bit got;
      model_access(cs2, a, d, be, rowd);
      drp_dbi_cs2_exp = cs2;
      drp_dbi_addr = a;
      drp_dbi_din = d;
      drp_dbi_wr = be;
      drp_app_dbi_ro_wr_disable = rowd;
      drp_dbi_cs = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (drp_lbc_dbi_ack) got = 1'b1;
      end
      if (got) chk("ack_latency", 32'(n - 1), 32'(ACK_LAT));
      else begin
         chk("ack_timeout", 32'd0, 32'd1);
         void'(sb_q.pop_back());
      end
      drive_idle();
      repeat (2) @(negedge clk);
   endtask

   task automatic rd(input logic cs2, input logic [31:0] a);
      acc(cs2, a, $urandom, 4'h0, 1'b0);
   endtask

   // Monitor: every ack pops one expected response
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && drp_lbc_dbi_ack) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            if (e.rd) chk("read_data", drp_lbc_dbi_dout, e.data);
            chk("err_flag", 32'(dbi_err), 32'(e.err));
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [3:0]  be;
      int          sel;
      rst_n = 1'b0;
      drive_idle();
      drp_app_dbi_ro_wr_disable = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_ack", 32'(drp_lbc_dbi_ack), 32'd0);
      chk("reset_dout", drp_lbc_dbi_dout, 32'd0);
      chk("reset_err", 32'(dbi_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic write/read, including an address just past the bank
      acc(1'b0, 32'h0000_00F0, 32'hA5A5_1234, 4'hF, 1'b0);
      rd(1'b0, 32'h0000_00F0);
      acc(1'b0, 32'h0000_0100, 32'hA5A5_1234, 4'hF, 1'b0);
      rd(1'b0, 32'h0000_0100);
      rd(1'b0, 32'h0000_0000);

      // Read-only gating and protect register
      acc(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd(1'b0, 32'h0000_0004);
      acc(1'b0, PROT_A, 32'h0000_0001, 4'h1, 1'b0);
      rd(1'b0, PROT_A);
      acc(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd(1'b0, 32'h0000_0004);
      acc(1'b0, 32'h0000_0004, 32'h1234_5678, 4'hF, 1'b1);
      rd(1'b0, 32'h0000_0004);
      acc(1'b0, 32'h0000_003C, 32'hCAFE_F00D, 4'hF, 1'b0);
      rd(1'b0, 32'h0000_003F);
      acc(1'b0, 32'h0000_0040, 32'h0BAD_CAFE, 4'hF, 1'b1);
      rd(1'b0, 32'h0000_0040);

      // Byte enables
      acc(1'b0, 32'h0000_00C0, 32'hFFFF_FFFF, 4'hF, 1'b0);
      acc(1'b0, 32'h0000_00C0, 32'h1122_3344, 4'b0101, 1'b0);
      rd(1'b0, 32'h0000_00C0);

      // Shadow bank independent and never read-only
      acc(1'b1, 32'h0000_00F0, 32'hDEAD_0001, 4'hF, 1'b1);
      rd(1'b1, 32'h0000_00F0);
      rd(1'b0, 32'h0000_00F0);
      acc(1'b1, 32'h0000_0008, 32'h5555_AAAA, 4'hF, 1'b1);
      rd(1'b1, 32'h0000_0008);
      rd(1'b1, PROT_A);

      // Out-of-range
      rd(1'b0, 32'h0000_FFF0);
      acc(1'b0, 32'h8000_0000, 32'h1, 4'hF, 1'b0);

      // Master abort in WAIT: no ack, no write
      acc(1'b0, 32'h0000_00C8, 32'h55AA_55AA, 4'hF, 1'b0);
      drp_dbi_cs = 1'b1; drp_dbi_addr = 32'h0000_00C8; drp_dbi_din = 32'h0000_0001; drp_dbi_wr = 4'hF;
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      repeat (4) @(negedge clk);
      rd(1'b0, 32'h0000_00C8);

      // Reset in WAIT: no ack, everything cleared, next access normal
      drp_dbi_cs = 1'b1; drp_dbi_addr = 32'h0000_00C8; drp_dbi_din = 32'h0000_0002; drp_dbi_wr = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      model_reset();
      #1;
      chk("midrst_ack", 32'(drp_lbc_dbi_ack), 32'd0);
      chk("midrst_dout", drp_lbc_dbi_dout, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(1'b0, 32'h0000_00C8);
      rd(1'b0, PROT_A);

      // Randomized traffic
      for (int it = 0; it < 200; it++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = PROT_A;
         else if (sel == 1) a = $urandom | 32'h0000_0100;
         else               a = {24'h0, 6'($urandom_range(0, NW - 1)), 2'($urandom)};
         be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         acc(1'($urandom), a, $urandom, be, ($urandom_range(0, 3) == 0));
      end

      repeat (4) @(negedge clk);
      chk("queue_drain", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
